branch_pred_ctrl: RTL and testbench
===================================

# branch_pred_ctrl

- Sequences the 2-bit saturating recommendation table for the fetch stage.
- Each cycle it can accept one branch lookup and one in-order branch resolution.
- Per lookup it drives the table read index, returns a taken/not-taken prediction and records the branch in an in-flight FIFO.
- Per resolution it pops that FIFO, issues a registered table update and flags mispredictions, flushing the wrong-path entries.

## Interface
- HISTORY_WIDTH, 3, table index width; must match the table instance.
- FIFO_DEPTH, 4, maximum in-flight branches; power of two, ≥2.
- CNT_WIDTH, 16, width of the mispredict statistics counter.

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- br_valid  in  1  fetch presents a branch for prediction.
- br_pc  in  HISTORY_WIDTH  low PC bits of that branch.
- br_ready  out  1  lookup accepted this cycle; high when FIFO not full.
- pred_taken  out  1  prediction for the current br_pc, combinational: tbl_rec[1].
- tbl_addr  out  HISTORY_WIDTH  table read index, combinational from br_pc.
- tbl_rec  in  2  table counter at tbl_addr.
- tbl_wr_addr  out  HISTORY_WIDTH  table update index, registered.
- tbl_update  out  1  one-cycle table update strobe, registered.
- tbl_taken  out  1  actual outcome for the update, registered.
- res_valid  in  1  execute stage resolves the oldest in-flight branch.
- res_taken  in  1  actual outcome of that branch.
- mispredict  out  1  one-cycle pulse, registered; fetch must redirect.
- inflight  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- mispred_count  out  CNT_WIDTH  saturating count of mispredictions.

## Operation
- **Index.** idx = br_pc. Under GSHARE_EN the index becomes idx = br_pc ^ ghr (see Configuration).
- **Lookup handshake.** A lookup is accepted when br_valid && br_ready. On acceptance, {idx, pred_taken} is pushed at the tail of the FIFO.
- **Resolution.** A resolution is accepted when res_valid && inflight != 0. On acceptance:
  - The head entry is popped.
  - Next cycle: tbl_update=1, tbl_wr_addr=head.idx, tbl_taken=res_taken.
  - If head.pred != res_taken: mispredict=1 next cycle, every FIFO entry is discarded (inflight→0) and mispred_count increments, saturating at all-ones.
- **Orphan resolution.** res_valid while inflight == 0 is ignored: no update, no mispredict, no count change.
- **Simultaneous lookup and resolution, correct prediction.** Push and pop both occur and inflight is unchanged. When the FIFO is full, br_ready stays 0 that cycle; there is no same-cycle pop-then-push bypass.
- **Simultaneous lookup and resolution, mispredict.** The concurrent push is wrong-path and is dropped: inflight becomes 0. br_ready is still asserted combinationally in that cycle.
- **Pointers.** Head and tail pointers wrap modulo FIFO_DEPTH. Full when inflight == FIFO_DEPTH; empty when inflight == 0.
- **Reset values** (rst at any time, including mid-operation):
  - FIFO emptied, pointers 0, inflight=0.
  - tbl_update=0, tbl_taken=0, tbl_wr_addr=0, mispredict=0.
  - mispred_count=0, ghr=0.
  - br_ready=1 the cycle after reset deasserts.

## Timing
- Lookup is zero-latency: tbl_addr and pred_taken are valid in the same cycle as br_pc.
- Table update and mispredict assert exactly 1 cycle after the accepting resolution edge. Each lasts exactly 1 cycle per resolution; back-to-back resolutions give back-to-back strobes.
- A lookup in the cycle where the table is written reads the pre-write counter value. No forwarding is performed.
- After a mispredict, inflight reads 0 in the cycle mispredict is high.

## Configuration
- GSHARE_EN defined:
  - A HISTORY_WIDTH-bit global history register ghr is maintained.
  - ghr is updated non-speculatively on each accepted resolution: ghr <= {ghr[HISTORY_WIDTH-2:0], res_taken}.
  - Lookup index is br_pc ^ ghr, using ghr's current value in the lookup cycle.
  - The stored FIFO index is the XORed value, so each update targets exactly the entry that was read.
- GSHARE_EN undefined: there is no ghr register and the index is br_pc.

## Test plan
- **Reset and simple lookup/update.** Apply reset; then br_pc=5 with tbl_rec=2'b00 → pred_taken=0, inflight=1. Then res_taken=0 → next cycle tbl_update=1, tbl_wr_addr=5, tbl_taken=0, mispredict=0.
- **Mispredict flush.** Push 3 lookups (pc 1,2,3) with tbl_rec=2'b11. Resolve the first with res_taken=0 → mispredict=1, tbl_wr_addr=1, inflight=0, mispred_count=1. A further res_valid while empty produces no tbl_update.
- **Full FIFO.** Push 4 lookups → br_ready=0 and inflight=4; a 5th br_valid is not accepted. Resolve one correctly while br_valid is held → no push that cycle, inflight=3; next cycle br_ready=1.
- **Simultaneous events.** With inflight=2, assert a correctly predicted resolution plus a lookup → inflight stays 2. Repeat with a mispredicted resolution → inflight=0 and the pushed entry is absent.
- **Wrap and counter saturation.** Run 20 push/resolve pairs so the pointers wrap 5 times; verify tbl_wr_addr order matches push order. With CNT_WIDTH=2, force 5 mispredicts → mispred_count=3.
- **GSHARE_EN.** Resolve the outcomes taken, taken, not-taken → ghr=3'b110. Lookup br_pc=3'b011 → tbl_addr=3'b101; its resolution updates tbl_wr_addr=3'b101. Assert rst mid-sequence → ghr=0 and inflight=0.

Source files
------------

// File: rtl/branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_pred_ctrl
// Description : Fetch-side sequencer for a 2-bit saturating recommendation
//               table. Drives the table read index, returns a taken/not-taken
//               prediction, tracks in-flight branches in a FIFO, issues
//               registered table updates on in-order resolution and flushes
//               wrong-path entries on a mispredict.
//               Optional feature: define GSHARE_EN to XOR the lookup index
//               with a non-speculative global history register.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_pred_ctrl #(
  parameter int HISTORY_WIDTH = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          br_valid,
  input  logic [HISTORY_WIDTH-1:0]      br_pc,
  output logic                          br_ready,
  output logic                          pred_taken,
  output logic [HISTORY_WIDTH-1:0]      tbl_addr,
  input  logic [1:0]                    tbl_rec,
  output logic [HISTORY_WIDTH-1:0]      tbl_wr_addr,
  output logic                          tbl_update,
  output logic                          tbl_taken,
  input  logic                          res_valid,
  input  logic                          res_taken,
  output logic                          mispredict,
  output logic [$clog2(FIFO_DEPTH):0]   inflight,
  output logic [CNT_WIDTH-1:0]          mispred_count
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_OCC_W = c_PTR_W + 1;
  localparam logic [c_OCC_W-1:0]   c_FULL    = c_OCC_W'(FIFO_DEPTH);
  localparam logic [c_OCC_W-1:0]   c_OCC_ONE = c_OCC_W'(1);
  localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  // In-flight branch storage: table index used for the lookup and the
  // prediction that was returned for it.
  logic [HISTORY_WIDTH-1:0] r_fifo_idx  [FIFO_DEPTH];
  logic                     r_fifo_pred [FIFO_DEPTH];
  logic [c_PTR_W-1:0]       r_head;
  logic [c_PTR_W-1:0]       r_tail;
  logic [c_OCC_W-1:0]       r_inflight;

  logic [HISTORY_WIDTH-1:0] w_idx;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_mis;
  logic [HISTORY_WIDTH-1:0] w_head_idx;
  logic                     w_head_pred;
  logic                     w_unused_rec_lsb;

`ifdef GSHARE_EN
  logic [HISTORY_WIDTH-1:0] r_ghr;

  // Global history advances only on resolved outcomes, never on predictions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
    end else if (w_pop) begin
      r_ghr <= {r_ghr[HISTORY_WIDTH-2:0], res_taken};
    end
  end

  assign w_idx = br_pc ^ r_ghr;
`else
  assign w_idx = br_pc;
`endif

  // Only the direction bit of the counter matters for the prediction.
  assign w_unused_rec_lsb = tbl_rec[0];

  assign tbl_addr    = w_idx;
  assign pred_taken  = tbl_rec[1];
  assign br_ready    = (r_inflight != c_FULL);
  assign inflight    = r_inflight;

  assign w_push      = br_valid && br_ready;
  assign w_pop       = res_valid && (r_inflight != '0);
  assign w_head_idx  = r_fifo_idx[r_head];
  assign w_head_pred = r_fifo_pred[r_head];
  // A mispredict squashes every younger entry, including one pushed this cycle.
  assign w_mis       = w_pop && (w_head_pred != res_taken);

  // FIFO payload write at the tail; contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_tail]  <= w_idx;
      r_fifo_pred[r_tail] <= pred_taken;
    end
  end

  // Pointer and occupancy bookkeeping, with flush on mispredict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= '0;
    end else if (w_mis) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_inflight <= r_inflight + c_OCC_ONE;
        2'b01:   r_inflight <= r_inflight - c_OCC_ONE;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Registered table update issued one cycle after each accepted resolution.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_update  <= 1'b0;
      tbl_wr_addr <= '0;
      tbl_taken   <= 1'b0;
    end else begin
      tbl_update <= w_pop;
      if (w_pop) begin
        tbl_wr_addr <= w_head_idx;
        tbl_taken   <= res_taken;
      end
    end
  end

  // Mispredict pulse and saturating statistics counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict    <= 1'b0;
      mispred_count <= '0;
    end else begin
      mispredict <= w_mis;
      if (w_mis && (mispred_count != '1)) begin
        mispred_count <= mispred_count + c_CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_pred_ctrl
// Description : Directed self-checking bench for branch_pred_ctrl
//               (HISTORY_WIDTH=3, FIFO_DEPTH=4, CNT_WIDTH=2). GSHARE_EN
//               selects the global-history checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pred_ctrl;

  logic       clk;
  logic       rst;
  logic       br_valid;
  logic [2:0] br_pc;
  logic       br_ready;
  logic       pred_taken;
  logic [2:0] tbl_addr;
  logic [1:0] tbl_rec;
  logic [2:0] tbl_wr_addr;
  logic       tbl_update;
  logic       tbl_taken;
  logic       res_valid;
  logic       res_taken;
  logic       mispredict;
  logic [2:0] inflight;
  logic [1:0] mispred_count;

  int errors = 0;
  int checks = 0;

  // Expected-state model: history register, queued indices, counter value.
  logic [2:0] ghr_m;
  logic [2:0] q[$];
  int         exp_cnt;

  branch_pred_ctrl #(
    .HISTORY_WIDTH(3),
    .FIFO_DEPTH   (4),
    .CNT_WIDTH    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .br_valid     (br_valid),
    .br_pc        (br_pc),
    .br_ready     (br_ready),
    .pred_taken   (pred_taken),
    .tbl_addr     (tbl_addr),
    .tbl_rec      (tbl_rec),
    .tbl_wr_addr  (tbl_wr_addr),
    .tbl_update   (tbl_update),
    .tbl_taken    (tbl_taken),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .mispredict   (mispredict),
    .inflight     (inflight),
    .mispred_count(mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] idx(input logic [2:0] pc);
`ifdef GSHARE_EN
    return pc ^ ghr_m;
`else
    return pc;
`endif
  endfunction

  task automatic push(input logic [2:0] pc, input logic [1:0] rec);
    logic [2:0] e;
    br_valid = 1'b1;
    br_pc    = pc;
    tbl_rec  = rec;
    #1;
    e = idx(pc);
    check("lk_addr", tbl_addr, e);
    check("lk_pred", pred_taken, rec[1]);
    check("lk_ready", br_ready, 1'b1);
    q.push_back(e);
    cyc;
    br_valid = 1'b0;
    check("lk_inflight", inflight, q.size());
  endtask

  task automatic resolve(input logic taken, input logic mis);
    logic [2:0] e;
    res_valid = 1'b1;
    res_taken = taken;
    cyc;
    res_valid = 1'b0;
    e = q.pop_front();
    if (mis) begin
      q.delete();
      if (exp_cnt < 3) exp_cnt++;
    end
    ghr_m = {ghr_m[1:0], taken};
    check("rs_update", tbl_update, 1'b1);
    check("rs_wr_addr", tbl_wr_addr, e);
    check("rs_taken", tbl_taken, taken);
    check("rs_mispredict", mispredict, mis);
    check("rs_count", mispred_count, exp_cnt);
    check("rs_inflight", inflight, q.size());
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc;
    cyc;
    rst = 1'b0;
    ghr_m   = '0;
    exp_cnt = 0;
    q.delete();
  endtask

  initial begin
    logic [2:0] e;
    logic [2:0] e_push;
    rst = 1'b1; br_valid = 1'b0; br_pc = '0; tbl_rec = '0;
    res_valid = 1'b0; res_taken = 1'b0;
    ghr_m = '0; exp_cnt = 0;

    // Reset state
    cyc;
    cyc;
    check("rst_inflight", inflight, 3'd0);
    check("rst_update", tbl_update, 1'b0);
    check("rst_taken", tbl_taken, 1'b0);
    check("rst_wr_addr", tbl_wr_addr, 3'd0);
    check("rst_mispredict", mispredict, 1'b0);
    check("rst_count", mispred_count, 2'd0);
    rst = 1'b0;
    cyc;
    check("rst_ready", br_ready, 1'b1);

    // Simple lookup and correctly predicted update
    push(3'd5, 2'b00);
    resolve(1'b0, 1'b0);
    cyc;
    check("upd_one_cycle", tbl_update, 1'b0);

    // Mispredict flush, then orphan resolution
    push(3'd1, 2'b11);
    push(3'd2, 2'b11);
    push(3'd3, 2'b11);
    resolve(1'b0, 1'b1);
    cyc;
    check("mis_one_cycle", mispredict, 1'b0);
    res_valid = 1'b1;
    res_taken = 1'b1;
    cyc;
    res_valid = 1'b0;
    check("orphan_update", tbl_update, 1'b0);
    check("orphan_mispredict", mispredict, 1'b0);
    check("orphan_count", mispred_count, 2'd1);

    // Full FIFO: fifth lookup held off, pop with no same-cycle push
    push(3'd4, 2'b00);
    push(3'd5, 2'b00);
    push(3'd6, 2'b00);
    push(3'd7, 2'b00);
    br_valid = 1'b1;
    br_pc    = 3'd0;
    #1;
    check("full_ready", br_ready, 1'b0);
    cyc;
    check("full_inflight", inflight, 3'd4);
    res_valid = 1'b1;
    res_taken = 1'b0;
    #1;
    check("full_pop_ready", br_ready, 1'b0);
    cyc;
    res_valid = 1'b0;
    e = q.pop_front();
    ghr_m = {ghr_m[1:0], 1'b0};
    check("full_after_inflight", inflight, 3'd3);
    check("full_after_wr_addr", tbl_wr_addr, e);
    check("full_after_ready", br_ready, 1'b1);
    br_valid = 1'b0;
    resolve(1'b0, 1'b0);
    resolve(1'b0, 1'b0);
    resolve(1'b0, 1'b0);

    // Simultaneous lookup and resolution
    push(3'd1, 2'b00);
    push(3'd2, 2'b00);
    br_valid = 1'b1; br_pc = 3'd3; tbl_rec = 2'b00;
    res_valid = 1'b1; res_taken = 1'b0;
    #1;
    e_push = idx(3'd3);
    cyc;
    br_valid = 1'b0; res_valid = 1'b0;
    e = q.pop_front();
    q.push_back(e_push);
    ghr_m = {ghr_m[1:0], 1'b0};
    check("sim_ok_inflight", inflight, 3'd2);
    check("sim_ok_wr_addr", tbl_wr_addr, e);
    check("sim_ok_mispredict", mispredict, 1'b0);
    br_valid = 1'b1; br_pc = 3'd4; tbl_rec = 2'b00;
    res_valid = 1'b1; res_taken = 1'b1;
    #1;
    check("sim_mis_ready", br_ready, 1'b1);
    cyc;
    br_valid = 1'b0; res_valid = 1'b0;
    e = q.pop_front();
    q.delete();
    exp_cnt = 2;
    ghr_m = {ghr_m[1:0], 1'b1};
    check("sim_mis_mispredict", mispredict, 1'b1);
    check("sim_mis_inflight", inflight, 3'd0);
    check("sim_mis_wr_addr", tbl_wr_addr, e);
    check("sim_mis_count", mispred_count, 2'd2);
    res_valid = 1'b1; res_taken = 1'b0;
    cyc;
    res_valid = 1'b0;
    check("sim_dropped_update", tbl_update, 1'b0);

    // Pointer wrap: 20 push/resolve pairs, updates follow push order
    for (int i = 0; i < 20; i++) begin
      push(3'(i), 2'b00);
      resolve(1'b0, 1'b0);
    end

    // Counter saturation at 2'b11
    for (int i = 0; i < 3; i++) begin
      push(3'(i + 2), 2'b11);
      resolve(1'b0, 1'b1);
    end
    check("sat_count", mispred_count, 2'd3);

    // Reset in the middle of operation
    push(3'd1, 2'b00);
    push(3'd2, 2'b00);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    ghr_m = '0; exp_cnt = 0; q.delete();
    check("midrst_inflight", inflight, 3'd0);
    check("midrst_count", mispred_count, 2'd0);
    check("midrst_ready", br_ready, 1'b1);

`ifdef GSHARE_EN
    // Global history: T, T, N gives 3'b110
    do_reset;
    cyc;
    push(3'd0, 2'b11);
    resolve(1'b1, 1'b0);
    push(3'd0, 2'b11);
    resolve(1'b1, 1'b0);
    push(3'd0, 2'b00);
    resolve(1'b0, 1'b0);
    br_pc = 3'b011;
    #1;
    check("gs_addr", tbl_addr, 3'b101);
    push(3'b011, 2'b00);
    resolve(1'b0, 1'b0);
    check("gs_wr_addr", tbl_wr_addr, 3'b101);
    push(3'd1, 2'b00);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    ghr_m = '0; exp_cnt = 0; q.delete();
    check("gs_rst_inflight", inflight, 3'd0);
    br_pc = 3'b011;
    #1;
    check("gs_rst_ghr", tbl_addr, 3'b011);
`else
    // Without history the index is the raw PC
    do_reset;
    cyc;
    push(3'd0, 2'b11);
    resolve(1'b1, 1'b0);
    br_pc = 3'b011;
    #1;
    check("plain_addr", tbl_addr, 3'b011);
`endif

    cyc;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
